// File: rtl/spi_pkg.sv
// Shared constants and the master state encoding for the SPI loopback.
package spi_pkg;
   localparam int DATA_W = 8;
   localparam int CNT_W  = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] DEF_TX_DATA = 8'hAA;
   localparam int DEF_CLK_DIV = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } mst_state_e;
endpackage

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI receiver: samples mosi on sclk rising strobes while ss is low.
module spi_slave_rx
   import spi_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk_rise,
   input  logic              ss,
   input  logic              mosi,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] dout_q;

   assign shift_d = {shift_q[DATA_W-2:0], mosi};

   // A deasserted ss discards any partial byte so it never reaches dout.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
      end else if (ss) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (sclk_rise) begin
         shift_q <= shift_d;
         if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_q  <= '0;
            dout_q <= shift_d;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/spi_loopback_top.sv
// SPI loopback: clock divider and mode-0 master FSM driving an internal slave.
module spi_loopback_top
   import spi_pkg::*;
#(
   parameter logic [DATA_W-1:0] TX_DATA = DEF_TX_DATA,
   parameter int                CLK_DIV = DEF_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_enable,
   output logic [DATA_W-1:0] dout
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] div_q;
   logic             sclk_q;
   logic             ss_q;
   logic             mosi_q;
   logic [CNT_W-1:0] bit_cnt_q;
   mst_state_e       state_q;

   logic div_wrap;
   logic sclk_rise;
   logic sclk_fall;

   // Strobes mark the clk cycle at whose end sclk changes level.
   assign div_wrap  = (div_q == DIV_W'(CLK_DIV - 1));
   assign sclk_rise = div_wrap & ~sclk_q;
   assign sclk_fall = div_wrap &  sclk_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else if (div_wrap) begin
         div_q  <= '0;
         sclk_q <= ~sclk_q;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // bit_cnt_q counts bits already driven after the MSB; the fall after the
   // last bit's rise closes the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ss_q      <= 1'b1;
         mosi_q    <= 1'b0;
         bit_cnt_q <= '0;
      end else if (sclk_fall) begin
         case (state_q)
            IDLE: begin
               if (tx_enable) begin
                  ss_q      <= 1'b0;
                  mosi_q    <= TX_DATA[DATA_W-1];
                  bit_cnt_q <= '0;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  ss_q      <= 1'b1;
                  mosi_q    <= 1'b0;
                  bit_cnt_q <= '0;
                  state_q   <= GAP;
               end else begin
                  mosi_q    <= TX_DATA[CNT_W'(DATA_W - 2) - bit_cnt_q];
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            GAP:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   spi_slave_rx u_rx (
      .clk       (clk),
      .rst       (rst),
      .sclk_rise (sclk_rise),
      .ss        (ss_q),
      .mosi      (mosi_q),
      .dout      (dout)
   );

endmodule

// File: tb/tb_spi_loopback_top.sv
// Directed bench for spi_loopback_top; observes internal SPI wires hierarchically.
module tb_spi_loopback_top;
   import spi_pkg::*;

   logic       clk;
   logic       rst;
   logic       tx_enable;
   logic [7:0] dout;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] exp_q[$];

   spi_loopback_top dut (
      .clk       (clk),
      .rst       (rst),
      .tx_enable (tx_enable),
      .dout      (dout)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver / wait tasks ----------------
   task automatic wait_ss(input logic lvl, input int bound, input string tag);
      int n = 0;
      while (dut.ss_q !== lvl && n < bound) begin
         tick();
         n++;
      end
      check(tag, 32'(dut.ss_q), 32'(lvl));
   endtask

   task automatic wait_rises(input int k, input string tag);
      int   cnt  = 0;
      int   n    = 0;
      logic prev = dut.sclk_q;
      while (cnt < k && n < 25 * k) begin
         tick();
         n++;
         if (prev === 1'b0 && dut.sclk_q === 1'b1) cnt++;
         prev = dut.sclk_q;
      end
      check(tag, 32'(cnt), 32'(k));
   endtask

   task automatic wait_dout(input int bound, input string tag);
      int n = 0;
      while (dout === 8'h00 && n < bound) begin
         tick();
         n++;
      end
      check({tag, "_value"}, 32'(dout), 32'hAA);
      check({tag, "_latency"}, 32'(n <= bound && dout !== 8'h00), 32'd1);
   endtask

   initial begin
      int   low_cnt;
      int   rise_cnt;
      int   rise_t0;
      int   rise_t1;
      int   frames;
      int   gap_run;
      int   min_gap;
      int   bad_dout;
      int   ss_low_seen;
      logic prev_sclk;
      logic prev_ss;

      // ---- 1: reset state held for 5 clocks ----
      rst       = 1'b1;
      tx_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_dout", 32'(dout), 32'h00);
         check("rst_ss", 32'(dut.ss_q), 32'd1);
         check("rst_sclk", 32'(dut.sclk_q), 32'd0);
      end

      // ---- 2: first byte arrives within 220 clks, no partial value first ----
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("idle_dout", 32'(dout), 32'h00);
      check("idle_ss", 32'(dut.ss_q), 32'd1);
      tx_enable = 1'b1;
      wait_dout(220, "first_byte");

      // ---- 3: bit stream, ss low width and sclk period of one frame ----
      wait_ss(1'b1, 100, "f3_gap");
      wait_ss(1'b0, 200, "f3_start");
      for (int b = 7; b >= 0; b--) exp_q.push_back({7'd0, DEF_TX_DATA[b]});
      low_cnt   = 1;
      rise_cnt  = 0;
      rise_t0   = 0;
      rise_t1   = 0;
      prev_sclk = dut.sclk_q;
      while (dut.ss_q === 1'b0 && low_cnt < 300) begin
         tick();
         if (dut.ss_q === 1'b0) low_cnt++;
         if (prev_sclk === 1'b0 && dut.sclk_q === 1'b1 && dut.ss_q === 1'b0) begin
            rise_cnt++;
            if (rise_cnt == 1) rise_t0 = low_cnt;
            if (rise_cnt == 2) rise_t1 = low_cnt;
            if (exp_q.size() > 0) check("mosi_bit", 32'(dut.mosi_q), 32'(exp_q.pop_front()));
            else check("mosi_extra_rise", 32'(rise_cnt), 32'd8);
         end
         prev_sclk = dut.sclk_q;
      end
      check("f3_rises", 32'(rise_cnt), 32'd8);
      check("f3_bits_left", 32'(exp_q.size()), 32'd0);
      check("f3_ss_low_clks", 32'(low_cnt), 32'd160);
      check("sclk_period", 32'(rise_t1 - rise_t0), 32'd20);
      check("f3_dout", 32'(dout), 32'hAA);

      // ---- 4: continuous transfers for 2000 clks ----
      frames   = 0;
      gap_run  = 0;
      min_gap  = 1000;
      bad_dout = 0;
      prev_ss  = dut.ss_q;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (dout !== 8'hAA) bad_dout++;
         if (dut.ss_q === 1'b1) gap_run++;
         if (prev_ss === 1'b1 && dut.ss_q === 1'b0) begin
            frames++;
            if (gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
         end
         if (dut.ss_q === 1'b0) gap_run = 0;
         prev_ss = dut.ss_q;
      end
      check("cont_dout_changes", 32'(bad_dout), 32'd0);
      check("cont_frames_ge9", 32'(frames >= 9), 32'd1);
      check("cont_gap_ge20", 32'(min_gap >= 20 && min_gap < 1000), 32'd1);

      // ---- 5: tx_enable dropped after the 3rd bit ----
      wait_ss(1'b1, 300, "f5_gap");
      wait_ss(1'b0, 300, "f5_start");
      wait_rises(3, "f5_three_bits");
      tx_enable = 1'b0;
      rise_cnt  = 0;
      low_cnt   = 0;
      prev_sclk = dut.sclk_q;
      while (dut.ss_q === 1'b0 && low_cnt < 300) begin
         tick();
         low_cnt++;
         if (prev_sclk === 1'b0 && dut.sclk_q === 1'b1 && dut.ss_q === 1'b0) rise_cnt++;
         prev_sclk = dut.sclk_q;
      end
      check("f5_remaining_rises", 32'(rise_cnt), 32'd5);
      ss_low_seen = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (dut.ss_q !== 1'b1) ss_low_seen++;
      end
      check("f5_ss_stays_high", 32'(ss_low_seen), 32'd0);
      check("f5_dout", 32'(dout), 32'hAA);
      check("f5_state_idle", 32'(dut.state_q), 32'(IDLE));

      // ---- 6: reset pulsed after the 4th bit ----
      tx_enable = 1'b1;
      wait_ss(1'b0, 300, "f6_start");
      wait_rises(4, "f6_four_bits");
      rst = 1'b1;
      tick();
      check("f6_rst_dout", 32'(dout), 32'h00);
      check("f6_rst_ss", 32'(dut.ss_q), 32'd1);
      check("f6_rst_sclk", 32'(dut.sclk_q), 32'd0);
      check("f6_rst_state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      wait_dout(220, "f6_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
